// File: rtl/mic_pkg.sv
// mic_pkg: shared constants and saturating output shift for the PDM mic front end.
package mic_pkg;
    localparam int PCM_W         = 16;
    localparam int PCM_MAX       = 32767;
    localparam int PCM_MIN       = -32768;
    localparam int CLK_DIV_DEF   = 4;
    localparam int DECIM_DEF     = 64;
    localparam int ACC_W_DEF     = 20;
    localparam int OUT_SHIFT_DEF = 3;

    function automatic logic signed [PCM_W-1:0] sat_shift(input logic signed [31:0] v, input int sh);
        logic signed [31:0] s;
        s = v >>> sh;
        return (s > PCM_MAX) ? PCM_W'(PCM_MAX) : (s < PCM_MIN) ? PCM_W'(PCM_MIN) : s[PCM_W-1:0];
    endfunction
endpackage

// File: rtl/pdm_mic_clkgen.sv
// pdm_mic_clkgen: phase counter producing the mic bit clock and the per-bit capture strobe.
module pdm_mic_clkgen
    import mic_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk_12m288,
    input  logic resetn,
    input  logic enable_i,
    output logic mic_clk_o,
    output logic bit_ce_o
);
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] ph_q, ph_d;
    logic          mic_clk_q;

    always_comb ph_d = !enable_i ? '0 : (ph_q == PW'(CLK_DIV - 1)) ? '0 : ph_q + 1'b1;

    // mic_clk is registered from the next phase so it tracks ph without a combinational glitch
    always_ff @(posedge clk_12m288 or negedge resetn) begin
        if (!resetn) begin
            ph_q      <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            mic_clk_q <= enable_i && (ph_d < PW'(CLK_DIV / 2));
        end
    end

    assign mic_clk_o = mic_clk_q;
    assign bit_ce_o  = enable_i && (ph_q == PW'(CLK_DIV - 1));
endmodule

// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: PDM mic front end - bit clock, 3rd-order CIC decimator to 16-bit PCM,
// and a one-entry valid/ready output buffer with sticky overrun.
module pdm_mic_capture
    import mic_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int DECIM     = DECIM_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic                    clk_12m288,
    input  logic                    resetn,
    input  logic                    enable,
    output logic                    mic_clk,
    output logic                    mic_lrsel,
    input  logic                    mic_data,
    output logic signed [PCM_W-1:0] pcm_data,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
);
    localparam int BW = $clog2(DECIM);

    logic                    bit_ce, wrap, dec_ce_q, valid_q, ovr_q;
    logic [1:0]              sync_q;
    logic [BW-1:0]           bcnt_q;
    logic signed [ACC_W-1:0] x, i1_q, i2_q, i3_q, i1_d, i2_d, i3_d, d1_q, d2_q, d3_q, c1, c2, c3;
    logic signed [PCM_W-1:0] pcm_q, y;

    pdm_mic_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_12m288(clk_12m288),
        .resetn    (resetn),
        .enable_i  (enable),
        .mic_clk_o (mic_clk),
        .bit_ce_o  (bit_ce)
    );

    // integrators chain on the freshly updated stage so the CIC has no extra bit latency
    always_comb begin
        x    = {{(ACC_W-1){~sync_q[1]}}, 1'b1};
        i1_d = i1_q + x;
        i2_d = i2_q + i1_d;
        i3_d = i3_q + i2_d;
        c1   = i3_q - d1_q;
        c2   = c1 - d2_q;
        c3   = c2 - d3_q;
        y    = sat_shift(32'(c3), OUT_SHIFT);
        wrap = bit_ce && (bcnt_q == '1);
    end

    always_ff @(posedge clk_12m288 or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= '0;
            bcnt_q   <= '0;
            dec_ce_q <= 1'b0;
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            pcm_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], mic_data};
            dec_ce_q <= wrap;
            if (!enable) begin
                bcnt_q <= '0;
                i1_q   <= '0;
                i2_q   <= '0;
                i3_q   <= '0;
                d1_q   <= '0;
                d2_q   <= '0;
                d3_q   <= '0;
            end else begin
                if (bit_ce) begin
                    bcnt_q <= bcnt_q + 1'b1;
                    i1_q   <= i1_d;
                    i2_q   <= i2_d;
                    i3_q   <= i3_d;
                end
                if (dec_ce_q) begin
                    d1_q <= i3_q;
                    d2_q <= c1;
                    d3_q <= c2;
                end
            end
            // a full buffer not drained this cycle keeps its sample and flags the new one as lost
            if (dec_ce_q && (!valid_q || pcm_ready)) pcm_q <= y;
            if (dec_ce_q) begin
                if (valid_q && !pcm_ready) ovr_q <= 1'b1;
                else valid_q <= 1'b1;
            end else if (pcm_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign mic_lrsel = 1'b0;
    assign pcm_data  = pcm_q;
    assign pcm_valid = valid_q;
    assign overrun   = ovr_q;
endmodule
